// File: rtl/alu_seq_ctrl_if.sv
// Bus between the ALU sequencer, its requesters and the combinational ALU.
// Request handshake: a request transfers on a rising clock edge where both
// req_valid and req_ready are high; req_op/req_a/req_b are only looked at on
// that edge, and req_ready is high only while the sequencer is idle.
// The slave modport is the sequencer. The master modport is the surrounding
// world: the requester drives req_*, and the ALU drives alu_c.
interface alu_seq_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [31:0] alu_y;
  logic [31:0] alu_b;
  logic [4:0]  alu_opcode;
  logic [63:0] alu_c;
  logic [31:0] zhi;
  logic [31:0] zlo;
  logic        done;
  logic        err;
  logic        busy;
  logic        state_dbg;   // 0 = IDLE, 1 = EXEC

  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_c,
    output req_ready, alu_y, alu_b, alu_opcode, zhi, zlo, done, err, busy,
           state_dbg
  );

  modport master (
    output req_valid, req_op, req_a, req_b, alu_c,
    input  req_ready, alu_y, alu_b, alu_opcode, zhi, zlo, done, err, busy,
           state_dbg
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer in front of the combinational ALU. It registers one
// operation onto the ALU inputs, holds them for a per-op cycle budget (so MUL
// and DIV can be constrained as multicycle paths), then captures the 64-bit
// result into zhi/zlo with a one-cycle done pulse.
// Optional feature: define ALU_SEQ_DIV0_TRAP_EN to short-circuit divide by
// zero into a one-cycle op that returns 0 with err set.
module alu_seq_ctrl #(
  parameter int MUL_CYCLES = 4,   // 1..32
  parameter int DIV_CYCLES = 8    // 1..32
) (
  input  logic          clock,
  input  logic          clear,    // synchronous, active-low
  alu_seq_ctrl_if.slave bus
);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  // Counter preloads are N-1; the counter hits zero on the last hold cycle.
  localparam logic [4:0] MUL_LOAD = 5'(MUL_CYCLES - 1);
  localparam logic [4:0] DIV_LOAD = 5'(DIV_CYCLES - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_t;

  function automatic logic op_legal(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
      OP_AND, OP_OR, OP_MUL, OP_DIV, OP_NEG, OP_NOT: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] y_q, y_d;
  logic [31:0] b_q, b_d;
  logic [4:0]  op_q, op_d;
  logic [31:0] zhi_q, zhi_d;
  logic [31:0] zlo_q, zlo_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  // Set at accept when the result must be forced to zero and flagged as err.
  logic        fz_q, fz_d;

  logic        div0_trap;

`ifdef ALU_SEQ_DIV0_TRAP_EN
  assign div0_trap = (bus.req_op == OP_DIV) && (bus.req_b == 32'd0);
`else
  assign div0_trap = 1'b0;
`endif

  // State and datapath registers with synchronous active-low clear.
  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      y_q     <= 32'd0;
      b_q     <= 32'd0;
      op_q    <= 5'd0;
      zhi_q   <= 32'd0;
      zlo_q   <= 32'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      fz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      b_q     <= b_d;
      op_q    <= op_d;
      zhi_q   <= zhi_d;
      zlo_q   <= zlo_d;
      done_q  <= done_d;
      err_q   <= err_d;
      fz_q    <= fz_d;
    end
  end

  // Next-state logic: accept in IDLE, count down in EXEC, capture at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    b_d     = b_q;
    op_d    = op_q;
    zhi_d   = zhi_q;
    zlo_d   = zlo_q;
    fz_d    = fz_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          y_d     = bus.req_a;
          b_d     = bus.req_b;
          op_d    = bus.req_op;
          state_d = S_EXEC;
          if (!op_legal(bus.req_op) || div0_trap) begin
            cnt_d = 5'd0;
            fz_d  = 1'b1;
          end else begin
            fz_d = 1'b0;
            if (bus.req_op == OP_MUL)      cnt_d = MUL_LOAD;
            else if (bus.req_op == OP_DIV) cnt_d = DIV_LOAD;
            else                           cnt_d = 5'd0;
          end
        end
      end
      S_EXEC: begin
        if (cnt_q == 5'd0) begin
          zhi_d   = fz_q ? 32'd0 : bus.alu_c[63:32];
          zlo_d   = fz_q ? 32'd0 : bus.alu_c[31:0];
          done_d  = 1'b1;
          err_d   = fz_q;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.busy       = (state_q == S_EXEC);
  assign bus.state_dbg  = state_q;
  assign bus.alu_y      = y_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_opcode = op_q;
  assign bus.zhi        = zhi_q;
  assign bus.zlo        = zlo_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: a behavioural ALU drives alu_c from the registered
// operands, and a reference model predicts cycle budget, result and err.
module tb_alu_seq_ctrl;
  localparam int MUL_N = 4;
  localparam int DIV_N = 8;
`ifdef ALU_SEQ_DIV0_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clock = 1'b0;
  logic clear = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  alu_seq_ctrl_if bus ();

  alu_seq_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  logic [4:0] legal_ops [13] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110,
                                 5'b00111, 5'b01000, 5'b01001, 5'b01010,
                                 5'b01011, 5'b01111, 5'b10000, 5'b10001,
                                 5'b10010};

  function automatic bit is_legal(input logic [4:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Behavioural ALU; zhi is zero for everything but MUL and DIV.
  function automatic logic [63:0] alu_ref(input logic [4:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa;
    logic [63:0] p;
    int sh;
    sa = a;
    sh = int'(b[4:0]);
    case (op)
      5'b00011: return {32'd0, a + b};
      5'b00100: return {32'd0, a - b};
      5'b00101: return {32'd0, a >> sh};
      5'b00110: return {32'd0, 32'(sa >>> sh)};
      5'b00111: return {32'd0, a << sh};
      5'b01000: return {32'd0, (a >> sh) | (a << ((32 - sh) % 32))};
      5'b01001: return {32'd0, (a << sh) | (a >> ((32 - sh) % 32))};
      5'b01010: return {32'd0, a & b};
      5'b01011: return {32'd0, a | b};
      5'b01111: begin p = {32'd0, a} * {32'd0, b}; return p; end
      5'b10000: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      5'b10001: return {32'd0, 32'd0 - a};
      5'b10010: return {32'd0, ~a};
      default:  return 64'hDEAD_BEEF_0BAD_F00D;
    endcase
  endfunction

  always_comb bus.alu_c = alu_ref(bus.alu_opcode, bus.alu_y, bus.alu_b);

  function automatic bit model_trap(input logic [4:0] op, input logic [31:0] b);
    return !is_legal(op) || (TRAP && op == 5'b10000 && b == 0);
  endfunction

  function automatic int model_n(input logic [4:0] op, input logic [31:0] b);
    if (model_trap(op, b)) return 1;
    if (op == 5'b01111)    return MUL_N;
    if (op == 5'b10000)    return DIV_N;
    return 1;
  endfunction

  function automatic logic [63:0] model_res(input logic [4:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    if (model_trap(op, b)) return 64'd0;
    return alu_ref(op, a, b);
  endfunction

  // Issues one op, then checks hold window, done cycle and the cycle after.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input string tag);
    int n;
    logic [63:0] exp;
    logic exp_err;
    n       = model_n(op, b);
    exp     = model_res(op, a, b);
    exp_err = model_trap(op, b);
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    @(posedge clock);
    #1;
    bus.req_valid = 1'b0;
    bus.req_op    = 5'($urandom);
    bus.req_a     = $urandom;
    bus.req_b     = $urandom;
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      vectors++;
      if (bus.busy !== 1'b1 || bus.req_ready !== 1'b0 || bus.done !== 1'b0 ||
          bus.alu_y !== a || bus.alu_b !== b || bus.alu_opcode !== op) begin
        miscompares++;
        $display("FAIL %s hold[%0d]: busy=%b ready=%b done=%b y=%h b=%h op=%b, want busy=1 ready=0 done=0 y=%h b=%h op=%b",
                 tag, k, bus.busy, bus.req_ready, bus.done, bus.alu_y, bus.alu_b,
                 bus.alu_opcode, a, b, op);
      end
    end
    @(negedge clock);
    vectors++;
    if (bus.done !== 1'b1 || bus.err !== exp_err || bus.req_ready !== 1'b1 ||
        bus.busy !== 1'b0 || {bus.zhi, bus.zlo} !== exp) begin
      miscompares++;
      $display("FAIL %s done: done=%b err=%b ready=%b busy=%b z=%h, want done=1 err=%b ready=1 busy=0 z=%h",
               tag, bus.done, bus.err, bus.req_ready, bus.busy, {bus.zhi, bus.zlo},
               exp_err, exp);
    end
    @(negedge clock);
    vectors++;
    if (bus.done !== 1'b0 || bus.err !== 1'b0 || {bus.zhi, bus.zlo} !== exp) begin
      miscompares++;
      $display("FAIL %s after: done=%b err=%b z=%h, want done=0 err=0 z=%h",
               tag, bus.done, bus.err, {bus.zhi, bus.zlo}, exp);
    end
  endtask

  task automatic test_reset();
    clear = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op = 5'd0;
    bus.req_a = 32'd0;
    bus.req_b = 32'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    vectors++;
    if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.err !== 1'b0 || bus.alu_y !== 32'd0 || bus.alu_b !== 32'd0 ||
        bus.alu_opcode !== 5'd0 || bus.zhi !== 32'd0 || bus.zlo !== 32'd0) begin
      miscompares++;
      $display("FAIL reset: ready=%b busy=%b done=%b err=%b y=%h b=%h op=%b zhi=%h zlo=%h, want ready=1 rest 0",
               bus.req_ready, bus.busy, bus.done, bus.err, bus.alu_y, bus.alu_b,
               bus.alu_opcode, bus.zhi, bus.zlo);
    end
    clear = 1'b1;
  endtask

  task automatic test_directed();
    run_op(5'b00011, 32'd5, 32'd7, "add_5_7");
    run_op(5'b01111, 32'h0001_0000, 32'h0001_0000, "mul_64k");
    run_op(5'b10000, 32'd17, 32'd5, "div_17_5");
    run_op(5'b11111, $urandom, $urandom, "illegal_1f");
    run_op(5'b10000, $urandom, 32'd0, "div_by_0");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a2, b2;
    a2 = $urandom;
    b2 = $urandom;
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_op = 5'b10000;
    bus.req_a = 32'd17;
    bus.req_b = 32'd5;
    @(posedge clock);
    #1;
    bus.req_op = 5'b00011;
    bus.req_a = a2;
    bus.req_b = b2;
    for (int k = 0; k < DIV_N; k++) begin
      @(negedge clock);
      vectors++;
      if (bus.busy !== 1'b1 || bus.alu_y !== 32'd17 || bus.alu_b !== 32'd5 ||
          bus.alu_opcode !== 5'b10000) begin
        miscompares++;
        $display("FAIL b2b hold[%0d]: busy=%b y=%h b=%h op=%b, want busy=1 y=11 b=5 op=10000",
                 k, bus.busy, bus.alu_y, bus.alu_b, bus.alu_opcode);
      end
    end
    @(negedge clock);
    vectors++;
    if (bus.done !== 1'b1 || bus.req_ready !== 1'b1 || bus.zhi !== 32'd2 ||
        bus.zlo !== 32'd3) begin
      miscompares++;
      $display("FAIL b2b first done: done=%b ready=%b zhi=%h zlo=%h, want done=1 ready=1 zhi=2 zlo=3",
               bus.done, bus.req_ready, bus.zhi, bus.zlo);
    end
    @(posedge clock);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clock);
    vectors++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.alu_y !== a2 ||
        bus.alu_opcode !== 5'b00011) begin
      miscompares++;
      $display("FAIL b2b second accept: busy=%b done=%b y=%h op=%b, want busy=1 done=0 y=%h op=00011",
               bus.busy, bus.done, bus.alu_y, bus.alu_opcode, a2);
    end
    @(negedge clock);
    vectors++;
    if (bus.done !== 1'b1 || {bus.zhi, bus.zlo} !== {32'd0, a2 + b2}) begin
      miscompares++;
      $display("FAIL b2b second done: done=%b z=%h, want done=1 z=%h",
               bus.done, {bus.zhi, bus.zlo}, {32'd0, a2 + b2});
    end
  endtask

  task automatic test_reset_mid_exec();
    int stray;
    run_op(5'b00011, 32'd100, 32'd23, "pre_reset_add");
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_op = 5'b01111;
    bus.req_a = 32'd9;
    bus.req_b = 32'd9;
    @(posedge clock);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    clear = 1'b1;
    vectors++;
    if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.zhi !== 32'd0 || bus.zlo !== 32'd0) begin
      miscompares++;
      $display("FAIL mid_reset: ready=%b busy=%b done=%b zhi=%h zlo=%h, want ready=1 busy=0 done=0 z=0",
               bus.req_ready, bus.busy, bus.done, bus.zhi, bus.zlo);
    end
    stray = 0;
    repeat (MUL_N + 4) begin
      @(negedge clock);
      if (bus.done !== 1'b0) stray++;
    end
    vectors++;
    if (stray !== 0) begin
      miscompares++;
      $display("FAIL mid_reset no_done: %0d done cycles seen, want 0", stray);
    end
    run_op(5'b00100, 32'd3, 32'd5, "sub_3_5");
    // Reset coincident with a valid request: the request is dropped.
    @(negedge clock);
    clear = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_op = 5'b01010;
    bus.req_a = 32'hFFFF;
    bus.req_b = 32'h0F0F;
    @(posedge clock);
    #1;
    bus.req_valid = 1'b0;
    clear = 1'b1;
    @(negedge clock);
    vectors++;
    if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1 || bus.alu_opcode !== 5'd0 ||
        bus.alu_y !== 32'd0) begin
      miscompares++;
      $display("FAIL clear_vs_valid: busy=%b ready=%b op=%b y=%h, want busy=0 ready=1 op=0 y=0",
               bus.busy, bus.req_ready, bus.alu_opcode, bus.alu_y);
    end
  endtask

  task automatic test_random();
    logic [4:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) op = 5'($urandom);
      else op = legal_ops[$urandom_range(0, 12)];
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      run_op(op, a, b, $sformatf("rand%0d_op%b", i, op));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_exec();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Multi-cycle sequencer that sits in front of the combinational ALU. It accepts one operation at a time over a valid/ready handshake and registers the operands and opcode onto the ALU inputs. It holds them stable for a per-operation cycle budget, so multiply and divide can be constrained as multicycle paths, then captures the 64-bit ALU result into the Z-high/Z-low registers with a one-cycle done pulse. Requesters are the control unit's issue stage and the test sequencer.

## Interface
- MUL_CYCLES, 4, cycles ALU inputs are held for multiply (legal range 1..32)
- DIV_CYCLES, 8, cycles ALU inputs are held for divide (legal range 1..32)
- clock  in  1  sole clock, all state updates on rising edge
- clear  in  1  synchronous, active-low reset (sampled on rising edge of clock)
- req_valid  in  1  request present
- req_ready  out  1  controller can accept (high only in IDLE)
- req_op  in  5  opcode
- req_a  in  32  first operand (drives ALU Y input)
- req_b  in  32  second operand (drives ALU B input)
- alu_y  out  32  registered ALU Y operand
- alu_b  out  32  registered ALU B operand
- alu_opcode  out  5  registered ALU opcode
- alu_c  in  64  ALU result
- zhi  out  32  captured result [63:32]
- zlo  out  32  captured result [31:0]
- done  out  1  one-cycle pulse; zhi/zlo valid from this cycle
- err  out  1  set with done when the op was illegal (or divide-by-zero, see Configuration)
- busy  out  1  high in EXEC

## Operation
- Opcode encodings: ADD 00011, SUB 00100, SHR 00101, SHRA 00110, SHL 00111, ROR 01000, ROL 01001, AND 01010, OR 01011, MUL 01111, DIV 10000, NEG 10001, NOT 10010. Every other value is illegal.
- States:
  - IDLE: req_ready=1.
  - On req_valid && req_ready: register req_a, req_b, req_op to alu_y, alu_b, alu_opcode; load cnt; go to EXEC.
- cnt load values: N-1, where N = MUL_CYCLES for MUL, DIV_CYCLES for DIV, and 1 for all other ops (including illegal).
- EXEC: alu_y, alu_b, alu_opcode held constant; cnt decrements each cycle.
  - When cnt==0, the next edge captures alu_c into {zhi,zlo}, sets done=1, and returns to IDLE.
- Illegal opcode: N=1; {zhi,zlo} forced to 0 (alu_c ignored); err=1 with done.
- err and done are registered pulses, cleared the cycle after they are asserted.
- zhi/zlo hold their value until the next capture.
- A new request is never accepted while in EXEC. req_* changes during EXEC are ignored.
- The controller performs no arithmetic. It relies on the ALU zero-filling zhi for all ops other than MUL/DIV.

## Timing
- Reset (clear=0 at an edge): state=IDLE, alu_y=0, alu_b=0, alu_opcode=0, zhi=0, zlo=0, done=0, err=0, busy=0, req_ready=1.
- Accept at edge E. The ALU inputs are valid from E through E+N. Capture happens at edge E+N; done/err are high in the cycle after E+N.
- req_ready is low from E to E+N and high again after E+N. With req_valid held, the next accept is at E+N+1, giving a throughput of N+1 cycles per op.
- done and req_ready are high in the same cycle, so a back-to-back accept coincides with the done pulse.
- Reset mid-EXEC: the op is abandoned, no done, zhi/zlo cleared, IDLE on the next cycle.
- clear=0 coincident with req_valid: reset wins and the request is not accepted.
- MUL_CYCLES=1 or DIV_CYCLES=1: same timing as a single-cycle op.

## Configuration
- `ALU_SEQ_DIV0_TRAP_EN` defined:
  - DIV with req_b==0 takes N=1 (no DIV_CYCLES wait).
  - {zhi,zlo} forced to 0, and err=1 with done.
- Undefined: DIV with B=0 runs the full DIV_CYCLES, captures alu_c unmodified, and err=0.

## Test plan
- Reset then idle: clear low 2 cycles -> all outputs 0 except req_ready=1. ADD a=5, b=7 -> done in the cycle after accept+1, zlo=12, zhi=0, err=0.
- MUL a=0x10000, b=0x10000 (MUL_CYCLES=4) -> alu_y/alu_b/alu_opcode stable for 4 cycles, req_ready low for 4 cycles, done at accept+5 with zhi=1, zlo=0.
- DIV a=17, b=5 (DIV_CYCLES=8) -> done after 8 hold cycles, {zhi,zlo} = alu_c (remainder 2, quotient 3 per ALU packing). Back-to-back with req_valid held: second accept lands in the done cycle.
- Illegal op 5'b11111 -> done after 1 cycle, err=1, zhi=zlo=0. DIV b=0: with trap enabled, 1 cycle and err=1; without it, 8 cycles and err=0.
- MUL issued, clear pulsed low at EXEC cycle 2 -> no done ever, zhi=zlo=0, req_ready=1 next cycle. A subsequent SUB a=3, b=5 -> zlo=0xFFFFFFFE.
